// File: rtl/fifo_drain_uart_tx.sv
// Drains bytes from an upstream FIFO and serialises each one as an 8N1 UART frame.
// A frame is fetched only while enable is high; reset aborts any frame in flight.
module fifo_drain_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    input  logic [7:0] fifo_data,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PEN  = CW'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_STOP
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shreg;
    logic          r_tx;
    logic          r_rd_en;
    logic          r_busy;
    logic          r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shreg <= '0;
            r_tx    <= 1'b1;
            r_rd_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable && !fifo_empty) begin
                        r_state <= S_FETCH;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_FETCH: r_state <= S_LOAD;
                S_LOAD: begin
                    // Read data is valid during LOAD, one cycle after the strobe.
                    r_shreg <= fifo_data;
                    r_tx    <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_START;
                end
                S_START: begin
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_tx    <= r_shreg[0];
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == LAST) begin
                        r_cnt <= '0;
                        if (r_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            // Bit 0 of the shifter is always the bit on the line.
                            r_idx   <= r_idx + 1'b1;
                            r_tx    <= r_shreg[1];
                            r_shreg <= {1'b0, r_shreg[7:1]};
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_done <= (r_cnt == PEN);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fifo_rd_en = r_rd_en;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign byte_done  = r_done;

endmodule

// File: tb/tb_fifo_drain_uart_tx.sv
// Bench for fifo_drain_uart_tx: FIFO model feeds a scoreboard of expected bytes,
// and an independent line monitor rebuilds each expected 8N1 frame and compares.
module tb_fifo_drain_uart_tx;

    localparam int CPB  = 4;
    localparam int FLEN = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_data = 8'h00;
    logic       tx;
    logic       busy;
    logic       byte_done;

    fifo_drain_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_data (fifo_data),
        .tx        (tx),
        .busy      (busy),
        .byte_done (byte_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int last_rd_cyc = -100;
    int frames_done = 0;
    int starts_q[$];
    int ends_q[$];
    logic [7:0] exp_q[$];

    logic [7:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: a strobe pops one byte, which is what the line must carry next.
    always @(posedge clk) begin
        if (fifo_rd_en === 1'b1) begin
            fifo_data <= mem[rd_ptr];
            exp_q.push_back(mem[rd_ptr]);
            rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, frames_done, target);
    endtask

    task automatic wait_tx_low(output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin : rd_track
        forever begin
            @(posedge clk); #1;
            if (fifo_rd_en === 1'b1) begin
                rd_cnt++;
                last_rd_cyc = cyc;
            end
        end
    end

    logic [7:0] m_d;
    logic [9:0] m_fr;
    int         m_st;
    bit         m_wave, m_done, m_busy, m_abort;

    initial begin : monitor
        forever begin
            @(posedge clk); #1;
            if (rst || tx !== 1'b0) continue;
            m_st = cyc;
            chk("start_latency", m_st - last_rd_cyc, 2);
            if (exp_q.size() == 0) begin
                chk("expected_byte_available", 0, 1);
                m_d = 8'h00;
            end else begin
                m_d = exp_q.pop_front();
            end
            m_fr    = {1'b1, m_d, 1'b0};
            m_wave  = 1'b1;
            m_done  = 1'b1;
            m_busy  = 1'b1;
            m_abort = 1'b0;
            for (int i = 0; i < FLEN; i++) begin
                if (i > 0) begin
                    @(posedge clk); #1;
                end
                if (rst) begin
                    m_abort = 1'b1;
                    break;
                end
                if (tx !== m_fr[i / CPB]) m_wave = 1'b0;
                if (byte_done !== (i == FLEN - 1)) m_done = 1'b0;
                if (busy !== 1'b1) m_busy = 1'b0;
            end
            if (!m_abort) begin
                chk($sformatf("frame_wave_0x%02h", m_d), int'(m_wave), 1);
                chk("frame_byte_done", int'(m_done), 1);
                chk("frame_busy", int'(m_busy), 1);
                starts_q.push_back(m_st);
                ends_q.push_back(cyc);
                frames_done++;
                @(posedge clk); #1;
                if (!rst) begin
                    chk("idle_tx_after_frame", int'(tx), 1);
                    chk("idle_busy_after_frame", int'(busy), 0);
                end
            end
        end
    end

    initial begin : stim
        bit ok;
        int k;
        int n;

        rst = 1'b1;
        cycles(3);
        chk("reset_tx", int'(tx), 1);
        chk("reset_rd_en", int'(fifo_rd_en), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_byte_done", int'(byte_done), 0);
        rst = 1'b0;
        cycles(2);
        chk("post_reset_no_fetch", rd_cnt, 0);

        // Single byte
        push(8'hA5);
        enable = 1'b1;
        wait_frames(1, 100, "single_frame");
        enable = 1'b0;
        cycles(5);
        chk("single_rd_pulses", rd_cnt, 1);

        // Burst of three, back to back
        k = starts_q.size();
        push(8'h00); push(8'hFF); push(8'h3C);
        enable = 1'b1;
        wait_frames(4, 300, "burst_frames");
        enable = 1'b0;
        cycles(5);
        chk("burst_rd_pulses", rd_cnt, 4);
        if (starts_q.size() >= k + 3) begin
            chk("burst_gap_0_1", starts_q[k+1] - ends_q[k], 4);
            chk("burst_gap_1_2", starts_q[k+2] - ends_q[k+1], 4);
        end else begin
            chk("burst_frame_record", starts_q.size(), k + 3);
        end

        // Gating: empty FIFO with enable, then data without enable
        enable = 1'b1;
        ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        chk("gate_fifo_empty", int'(ok), 1);
        enable = 1'b0;
        push(8'h55); push(8'h99); push(8'h77);
        ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        chk("gate_enable_low", int'(ok), 1);
        chk("gate_rd_pulses", rd_cnt, 4);

        // Enable drop during data bit 3 of 0x55
        enable = 1'b1;
        wait_tx_low(ok);
        chk("drop_frame_started", int'(ok), 1);
        cycles(1 + 4 * CPB);
        enable = 1'b0;
        wait_frames(5, 100, "drop_frame_completes");
        cycles(60);
        chk("drop_rd_pulses", rd_cnt, 5);
        chk("drop_no_more_frames", frames_done, 5);

        // Reset during data bit 5 of 0x99; next frame must carry 0x77
        enable = 1'b1;
        wait_tx_low(ok);
        chk("rst_frame_started", int'(ok), 1);
        cycles(1 + 6 * CPB);
        rst = 1'b1;
        #1;
        chk("rst_mid_tx", int'(tx), 1);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_rd_en", int'(fifo_rd_en), 0);
        cycles(3);
        rst = 1'b0;
        wait_frames(6, 100, "post_rst_frame");
        enable = 1'b0;
        cycles(5);
        chk("post_rst_rd_pulses", rd_cnt, 7);

        // Random bytes with random enable pauses
        for (int i = 0; i < 8; i++) push(8'($urandom_range(0, 255)));
        n = 0;
        while (frames_done < 14 && n < 3000) begin
            @(negedge clk);
            enable = ($urandom_range(0, 9) != 0);
            n++;
        end
        enable = 1'b0;
        cycles(5);
        chk("random_frames", frames_done, 14);
        chk("random_rd_pulses", rd_cnt, 15);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("fifo_drained", int'(fifo_empty), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
